// File: rtl/dma_addr_word_gen.sv
// DMA address / word-count generator.
// An address counter and a word counter, each with a reload copy loaded
// alongside it. The counters step together once per enabled cycle until the
// word count runs out. Parallel loads override reinit, and reinit overrides
// stepping, but only for the counter that the higher-priority action touches.
module dma_addr_word_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] di,
  input  logic             plwr_addr,
  input  logic             plwr_wc,
  input  logic             reinit,
  input  logic             cnt_en,
  input  logic             dir,
  output logic [WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0] wc_o,
  output logic             aco,
  output logic             done
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] addr_reg_q, addr_reg_d;
  logic [WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [WIDTH-1:0] wc_reg_q,   wc_reg_d;
  logic [WIDTH-1:0] wc_cnt_q,   wc_cnt_d;
  logic             done_q,     done_d;

  logic addr_load, wc_load;
  logic addr_step, wc_step;

  // Each path has its own step eligibility, so loading one path does not
  // stall the other.
  assign addr_load = ~plwr_addr;
  assign wc_load   = ~plwr_wc;
  assign addr_step = cnt_en & ~done_q & ~addr_load & ~reinit;
  assign wc_step   = cnt_en & ~done_q & ~wc_load   & ~reinit;

  // Next-state logic for both paths and the done flag.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    addr_reg_d = addr_reg_q;
    addr_cnt_d = addr_cnt_q;
    wc_reg_d   = wc_reg_q;
    wc_cnt_d   = wc_cnt_q;
    done_d     = done_q;

    if (addr_load) begin
      addr_reg_d = di;
      addr_cnt_d = di;
    end else if (reinit) begin
      addr_cnt_d = addr_reg_q;
    end else if (addr_step) begin
      addr_cnt_d = dir ? addr_cnt_q - ONE : addr_cnt_q + ONE;
    end

    if (wc_load) begin
      wc_reg_d = di;
      wc_cnt_d = di;
      done_d   = 1'b0;
    end else if (reinit) begin
      wc_cnt_d = wc_reg_q;
      done_d   = 1'b0;
    end else if (wc_step) begin
      wc_cnt_d = wc_cnt_q - ONE;
      // A count of zero means a full 2^WIDTH transfer, so only 1 -> 0 ends it.
      if (wc_cnt_q == ONE) done_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg_q <= '0;
      addr_cnt_q <= '0;
      wc_reg_q   <= '0;
      wc_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      addr_reg_q <= addr_reg_d;
      addr_cnt_q <= addr_cnt_d;
      wc_reg_q   <= wc_reg_d;
      wc_cnt_q   <= wc_cnt_d;
      done_q     <= done_d;
    end
  end

  // Carry out warns of the address wrap that the coming edge will produce.
  assign aco = addr_step & (dir ? (addr_cnt_q == '0) : (addr_cnt_q == ALL_ONES));

  assign addr_o = addr_cnt_q;
  assign wc_o   = wc_cnt_q;
  assign done   = done_q;

endmodule

// File: doc/dma_addr_word_gen.md
Name: dma_addr_word_gen

Overview:
- Parametrised successor to the single 4-bit pipeline-write register.
- Pairs an address register/counter with a word-count register/counter, modelled on the Am2940 address/word-count core.
- Each counter has a reload (reinitialise) copy.
- Supports up/down address stepping, terminal-count carry out and a transfer-done flag.
- Sits between the control-register decode and the memory-address bus of the DMA generator.

Parameters:
- WIDTH, 8, bit width of data input, address path and word-count path (min 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- di  in  WIDTH  parallel load data.
- plwr_addr  in  1  active-low address write; loads addr_reg and addr_cnt from di.
- plwr_wc  in  1  active-low word-count write; loads wc_reg and wc_cnt from di.
- reinit  in  1  active-high; copies addr_reg->addr_cnt and wc_reg->wc_cnt.
- cnt_en  in  1  active-high; one transfer step per cycle.
- dir  in  1  address direction: 0 increment, 1 decrement.
- addr_o  out  WIDTH  current address counter value.
- wc_o  out  WIDTH  current word counter value.
- aco  out  1  address carry out, combinational.
- done  out  1  registered transfer-complete flag.

Behaviour:
- Reset: addr_reg, addr_cnt, wc_reg and wc_cnt all 0; done=0. aco is 0 because it depends on a step being taken.
- Priority per edge, highest first: rst > load (plwr_addr / plwr_wc) > reinit > count.
- A lower-priority action is suppressed only for the counter that a higher-priority action touches in that cycle.
- Address load (plwr_addr=0): addr_reg<=di, addr_cnt<=di.
- Word-count load (plwr_wc=0): wc_reg<=di, wc_cnt<=di, done<=0.
- Both loads low in the same cycle: both paths load the same di value.
- Load while cnt_en=1: the loaded path does not step that cycle. The other path still steps if it is eligible.
- reinit=1 with no load: addr_cnt<=addr_reg, wc_cnt<=wc_reg, done<=0.
  - reinit combined with a load of one path: the loaded path takes di; the other path reinitialises.
- Step eligibility: cnt_en=1 and done=0 and no load or reinit.
- Step action:
  - addr_cnt <= addr_cnt+1 (dir=0) or addr_cnt-1 (dir=1), modulo 2^WIDTH with wrap and no saturation.
  - wc_cnt <= wc_cnt-1, modulo 2^WIDTH.
- Word count 0 means 2^WIDTH transfers: stepping from 0 wraps to all-ones and done stays 0.
- done: set to 1 on the edge where a step takes wc_cnt from 1 to 0.
  - Held until a word-count load, a reinit or rst.
  - While done=1, cnt_en is ignored and both counters hold.
- aco=1 only when the step is eligible this cycle and either:
  - dir=0 and addr_cnt is all ones, or
  - dir=1 and addr_cnt is 0.
- Otherwise aco=0. aco flags the wrap that occurs on the coming edge.
- Latency:
  - addr_o/wc_o reflect a load, reinit or step one edge later.
  - done asserts on the same edge that wc_o becomes 0.
- Reset mid-transfer: all state returns to reset values on that edge, regardless of other inputs.
- Inputs are sampled only at the rising edge; there is no combinational path from di to any output.

Test Plan:
1. rst=1 for 2 cycles with plwr_addr=0 and di=8'hA5 -> addr_o=0, wc_o=0, done=0, aco=0; load ignored.
2. Load addr 8'h10 and wc 8'h03, then cnt_en=1, dir=0 for 5 cycles -> addr_o 11,12,13 then holds; wc_o 2,1,0; done=1 on the third step edge; no further change.
3. Load addr 8'h00, dir=1, wc 8'h02, cnt_en=1 -> aco=1 in the first step cycle; addr_o wraps to 8'hFF then 8'hFE; done=1.
4. After scenario 2 completes, reinit=1 for one cycle -> addr_o=8'h10, wc_o=8'h03, done=0; counting resumes correctly.
5. Load wc 8'h00, cnt_en=1 -> wc_o=8'hFF after the first step, done stays 0; done=1 after exactly 256 steps.
6. During counting, assert plwr_addr=0 with di=8'h40 while cnt_en=1 -> addr_o=8'h40 with no step that cycle; wc_o still decrements; then rst=1 mid-transfer -> all outputs 0 on the next edge.
